reserve_station_queue: RTL and testbench
========================================

// Module: reserve_station_queue
// PURPOSE
//  Age-ordered reservation-station buffer between dispatch and one functional unit.
//  Holds dispatched instructions and captures missing operands from the CDB each cycle.
//  Per-entry operand capture is done through read_operands.
//  Issues the oldest entry whose operands are both ready to the FU over a valid/ready handshake.
// PARAMETERS
//  DEPTH  4  number of entries; must be >= 2.
// PORTS
//  clk             in   1                        clock; all state updates on posedge.
//  rst_n           in   1                        asynchronous, active-low reset.
//  flush           in   1                        discard all entries (mispredict/exception).
//  dispatch_valid  in   1                        dispatch offers dispatch_rs.
//  dispatch_rs     in   $bits(reserve_station_t)  incoming entry (operand, operand_addr, operand_ready, op info).
//  dispatch_ready  out  1                        entry accepted when dispatch_valid & dispatch_ready.
//  cdb_packet      in   $bits(cdb_packet_t)      CDB_SIZE broadcast lanes {valid, reorder, value}.
//  issue_valid     out  1                        issue_rs is the oldest fully-ready entry.
//  issue_ready     in   1                        FU accepts; the entry leaves on valid & ready.
//  issue_rs        out  $bits(reserve_station_t)  entry to execute; both operand_ready bits set.
//  count           out  $clog2(DEPTH+1)          occupied entries.
// BEHAVIOUR
//  Storage and ordering
//   - Collapsing queue: entries [0..count-1] are valid; index 0 is the oldest.
//   - New entries are written at index count (after collapse, see below).
//  Wakeup
//   - Every valid entry passes through read_operands every cycle and registers the result.
//   - The incoming dispatch_rs also passes through read_operands before it is written.
//   - A CDB hit in the dispatch cycle is therefore captured; no broadcast is missed.
//  Issue select
//   - Uses registered state only: sel = lowest valid index with operand_ready == 2'b11.
//   - issue_valid = a sel exists; issue_rs = entry[sel]. Combinational from flops, no CDB path.
//   - An operand arriving on the CDB in cycle N makes its entry issuable in cycle N+1 at the earliest.
//   - issue_valid/issue_rs stay stable while issue_ready is low, unless an older entry becomes ready.
//  Dequeue
//   - On issue fire, entries above sel shift down by one in the same edge.
//   - The shifted entries still receive this cycle's CDB capture.
//  Dispatch
//   - dispatch_ready = (count != DEPTH); registered-count based, with no full-queue pass-through.
//   - Dispatch and issue in the same cycle: the new entry lands at index count-1; count is unchanged.
//  Count update
//   - count_next = count + dispatch_fire - issue_fire.
//   - Never exceeds DEPTH and never underflows; an assertion checks both.
//  Latency
//   - Dispatch at edge N with both operands ready gives issue_valid high in cycle N+1.
//  Flush
//   - Highest priority: count <= 0 next edge.
//   - Dispatch and issue in the flush cycle are ignored; the FU must ignore issue_valid while flush=1.
//  Reset (rst_n low, asynchronous)
//   - count=0, all entry valid bits 0, issue_valid=0, dispatch_ready=1, issue_rs=0.
//   - Reset mid-operation drops all entries immediately.
//  Empty and full
//   - Empty: issue_valid=0.
//   - Full: dispatch_ready=0; it returns to 1 the cycle after any issue.
// STRUCTURE
//  - cpu_defs.svh (shared): reserve_station_t, cdb_packet_t, CDB_SIZE.
//  - Local: entry array reserve_station_t [DEPTH-1:0] plus the count register.
//  - Sub-modules: DEPTH+1 read_operands instances (one per entry, one on the dispatch path).
//  - Select logic is a priority encoder in this file; no other sub-module.
// TESTING
//  1. Dispatch {ready=2'b11, operand={5,7}} into empty queue
//     -> issue_valid=1 next cycle, issue_rs.operand={5,7}, count 1 -> 0 on fire.
//  2. Dispatch entry waiting on ROB tag 3 (operand 0); CDB lane 1 {valid, reorder=3, value=0xDEAD} same cycle
//     -> entry issues next cycle with operand[0]=0xDEAD.
//  3. Fill DEPTH=4 entries all waiting -> dispatch_ready=0, count=4;
//     CDB wakes entry 2 -> entry 2 issues; entry 3 moves to index 2; dispatch_ready=1.
//  4. Entries 0 and 1 both ready, issue_ready=0 for 3 cycles
//     -> issue_rs holds entry 0 throughout; fires on ready; entry 1 issues next cycle.
//  5. Dispatch, issue and a CDB hit for a shifting entry all in one cycle
//     -> count unchanged, shifted entry captures value, no entry lost or duplicated.
//  6. flush (or rst_n low) with count=3 and dispatch_valid=1
//     -> count=0, issue_valid=0 next cycle (immediately for reset), flushed dispatch not stored.

Source files
------------

// File: rtl/reserve_station_queue_pkg.sv
// Shared types for the reservation-station queue: entry layout and CDB broadcast lanes.
package reserve_station_queue_pkg;

  localparam int unsigned Xlen     = 32;
  localparam int unsigned TagW     = 4;
  localparam int unsigned CDB_SIZE = 2;

  typedef struct packed {
    logic [7:0]                 op;
    logic [TagW-1:0]            dest;
    logic [1:0]                 operand_ready;
    logic [1:0][TagW-1:0]       operand_addr;
    logic [1:0][Xlen-1:0]       operand;
  } reserve_station_t;

  typedef struct packed {
    logic            valid;
    logic [TagW-1:0] reorder;
    logic [Xlen-1:0] value;
  } cdb_lane_t;

  typedef cdb_lane_t [CDB_SIZE-1:0] cdb_packet_t;

  localparam int unsigned RsW  = $bits(reserve_station_t);
  localparam int unsigned CdbW = $bits(cdb_packet_t);

endpackage

// File: rtl/reserve_station_queue_read_operands.sv
// Operand wakeup: fills any not-yet-ready operand whose ROB tag matches a valid CDB lane.
module reserve_station_queue_read_operands
  import reserve_station_queue_pkg::*;
(
  input  logic [RsW-1:0]  rs_i,
  input  logic [CdbW-1:0] cdb_i,
  output logic [RsW-1:0]  rs_o
);

  reserve_station_t rs_in, rs_out;
  cdb_packet_t      cdb;

  assign rs_in = rs_i;
  assign cdb   = cdb_i;
  assign rs_o  = rs_out;

  always_comb begin
    rs_out = rs_in;
    for (int op = 0; op < 2; op++) begin
      // Walk lanes high to low so the lowest matching lane wins.
      for (int l = int'(CDB_SIZE) - 1; l >= 0; l--) begin
        if (!rs_in.operand_ready[op] && cdb[l].valid &&
            cdb[l].reorder == rs_in.operand_addr[op]) begin
          rs_out.operand[op]       = cdb[l].value;
          rs_out.operand_ready[op] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/reserve_station_queue.sv
// Age-ordered collapsing reservation station: CDB wakeup per entry, oldest-ready issue select.
module reserve_station_queue
  import reserve_station_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       dispatch_valid,
  input  logic [RsW-1:0]             dispatch_rs,
  output logic                       dispatch_ready,
  input  logic [CdbW-1:0]            cdb_packet,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [RsW-1:0]             issue_rs,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = $clog2(DEPTH);

  reserve_station_t [DEPTH-1:0] entries_q, entries_d, woken;
  reserve_station_t             disp_woken;
  logic [CntW-1:0]              count_q, count_d, wr_idx;
  logic [IdxW-1:0]              sel;
  logic                         sel_found, issue_fire, dispatch_fire;

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_wake
    reserve_station_queue_read_operands u_read_operands (
      .rs_i  (entries_q[g]),
      .cdb_i (cdb_packet),
      .rs_o  (woken[g])
    );
  end

  reserve_station_queue_read_operands u_read_operands_disp (
    .rs_i  (dispatch_rs),
    .cdb_i (cdb_packet),
    .rs_o  (disp_woken)
  );

  // Select uses registered state only, so there is no CDB-to-issue combinational path.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (CntW'(i) < count_q && entries_q[i].operand_ready == 2'b11) begin
        sel       = IdxW'(i);
        sel_found = 1'b1;
      end
    end
  end

  assign issue_valid    = sel_found;
  assign issue_rs       = sel_found ? entries_q[sel] : '0;
  assign dispatch_ready = (count_q != CntW'(DEPTH));
  assign count          = count_q;

  always_comb begin
    issue_fire    = sel_found & issue_ready & ~flush;
    dispatch_fire = dispatch_valid & dispatch_ready & ~flush;
    wr_idx        = count_q - CntW'(issue_fire);

    for (int i = 0; i < int'(DEPTH); i++) begin
      entries_d[i] = woken[i];
    end
    if (issue_fire) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        if (IdxW'(i) >= sel) entries_d[i] = woken[i+1];
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (dispatch_fire && CntW'(i) == wr_idx) entries_d[i] = disp_woken;
    end

    if (flush) count_d = '0;
    else       count_d = count_q + CntW'(dispatch_fire) - CntW'(issue_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_q <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
    end
  end

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CntW'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(issue_fire && count_q == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(dispatch_fire && !issue_fire && count_q == CntW'(DEPTH)));

endmodule

// File: tb/tb_reserve_station_queue.sv
// Bench for reserve_station_queue: queue-based reference model, per-cycle compare, directed cases.
module tb_reserve_station_queue;
  import reserve_station_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n, flush, dispatch_valid, dispatch_ready;
  logic             issue_valid, issue_ready;
  reserve_station_t dispatch_rs, issue_rs;
  cdb_packet_t      cdb_packet;
  logic [2:0]       count;

  int n_cmp = 0;
  int n_bad = 0;

  reserve_station_t mq[$];  // model contents, index 0 oldest

  reserve_station_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .dispatch_valid (dispatch_valid),
    .dispatch_rs    (dispatch_rs),
    .dispatch_ready (dispatch_ready),
    .cdb_packet     (cdb_packet),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_rs       (issue_rs),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic reserve_station_t wake(input reserve_station_t e, input cdb_packet_t c);
    reserve_station_t r = e;
    for (int op = 0; op < 2; op++) begin
      if (!r.operand_ready[op]) begin
        for (int l = 0; l < int'(CDB_SIZE); l++) begin
          if (c[l].valid && c[l].reorder == r.operand_addr[op]) begin
            r.operand[op]       = c[l].value;
            r.operand_ready[op] = 1'b1;
            break;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic int oldest_ready();
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].operand_ready == 2'b11) return i;
    end
    return -1;
  endfunction

  function automatic reserve_station_t mk(input logic [1:0] rdy, input logic [3:0] a0,
                                          input logic [31:0] v0, input logic [31:0] v1,
                                          input logic [7:0] op);
    reserve_station_t e = '0;
    e.op               = op;
    e.dest             = 4'hF;
    e.operand_ready    = rdy;
    e.operand_addr[0]  = a0;
    e.operand[0]       = v0;
    e.operand[1]       = v1;
    return e;
  endfunction

  // Outputs are functions of registered state only; check them mid-cycle against the model.
  always @(negedge clk) begin : cmp
    int s;
    if (rst_n) begin
      s = oldest_ready();
      chk("count", 128'(count), 128'(mq.size()));
      chk("dispatch_ready", 128'(dispatch_ready), 128'(mq.size() != DEPTH));
      chk("issue_valid", 128'(issue_valid), 128'(s >= 0));
      if (s >= 0) chk("issue_rs", 128'(issue_rs), 128'(mq[s]));
    end
  end

  task automatic tick();
    int s;
    bit ifire, dfire;
    s     = oldest_ready();
    ifire = !flush && s >= 0 && issue_ready;
    dfire = !flush && dispatch_valid && mq.size() < DEPTH;
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (ifire) mq.delete(s);
      foreach (mq[i]) mq[i] = wake(mq[i], cdb_packet);
      if (dfire) mq.push_back(wake(dispatch_rs, cdb_packet));
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush          = 1'b0;
    dispatch_valid = 1'b0;
    dispatch_rs    = '0;
    issue_ready    = 1'b0;
    cdb_packet     = '0;
  endtask

  task automatic push(input reserve_station_t e);
    dispatch_valid = 1'b1;
    dispatch_rs    = e;
    tick();
    dispatch_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("reset_count", 128'(count), 128'(0));
    chk("reset_dispatch_ready", 128'(dispatch_ready), 128'(1));
    chk("reset_issue_valid", 128'(issue_valid), 128'(0));
    chk("reset_issue_rs", 128'(issue_rs), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ready-on-dispatch entry issues the next cycle.
    push(mk(2'b11, 4'd0, 32'd5, 32'd7, 8'h01));
    chk("t1_issue_valid", 128'(issue_valid), 128'(1));
    chk("t1_operand0", 128'(issue_rs.operand[0]), 128'(5));
    chk("t1_operand1", 128'(issue_rs.operand[1]), 128'(7));
    chk("t1_count1", 128'(count), 128'(1));
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("t1_count0", 128'(count), 128'(0));

    // CDB hit in the dispatch cycle is captured.
    dispatch_valid = 1'b1;
    dispatch_rs    = mk(2'b10, 4'd3, 32'd0, 32'd9, 8'h02);
    cdb_packet[1]  = '{valid: 1'b1, reorder: 4'd3, value: 32'hDEAD};
    tick();
    idle_inputs();
    chk("t2_issue_valid", 128'(issue_valid), 128'(1));
    chk("t2_operand0", 128'(issue_rs.operand[0]), 128'(32'hDEAD));
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;

    // Full queue, wake the third entry, then the fourth after it collapses down.
    for (int k = 0; k < 4; k++) push(mk(2'b10, 4'(8 + k), 32'd0, 32'(k), 8'(8'h10 + k)));
    chk("t3_count_full", 128'(count), 128'(4));
    chk("t3_dispatch_ready_full", 128'(dispatch_ready), 128'(0));
    chk("t3_issue_valid_none", 128'(issue_valid), 128'(0));
    cdb_packet[0] = '{valid: 1'b1, reorder: 4'd10, value: 32'hC0FFEE};
    tick();
    cdb_packet = '0;
    chk("t3_issue_op", 128'(issue_rs.op), 128'(8'h12));
    chk("t3_issue_operand0", 128'(issue_rs.operand[0]), 128'(32'hC0FFEE));
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    chk("t3_count_after", 128'(count), 128'(3));
    chk("t3_dispatch_ready_after", 128'(dispatch_ready), 128'(1));
    cdb_packet[0] = '{valid: 1'b1, reorder: 4'd11, value: 32'h1111};
    tick();
    cdb_packet = '0;
    chk("t3_shifted_op", 128'(issue_rs.op), 128'(8'h13));
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Oldest ready holds while the FU stalls.
    push(mk(2'b11, 4'd0, 32'd100, 32'd1, 8'h20));
    push(mk(2'b11, 4'd0, 32'd200, 32'd2, 8'h21));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_hold", 128'(issue_rs.op), 128'(8'h20));
    end
    issue_ready = 1'b1;
    tick();
    chk("t4_second", 128'(issue_rs.op), 128'(8'h21));
    tick();
    issue_ready = 1'b0;
    chk("t4_empty", 128'(count), 128'(0));

    // Dispatch, issue and a CDB hit on a shifting entry all in one cycle.
    push(mk(2'b11, 4'd0, 32'd1, 32'd1, 8'h30));
    push(mk(2'b10, 4'd5, 32'd0, 32'd1, 8'h31));
    issue_ready    = 1'b1;
    dispatch_valid = 1'b1;
    dispatch_rs    = mk(2'b11, 4'd0, 32'd3, 32'd3, 8'h32);
    cdb_packet[0]  = '{valid: 1'b1, reorder: 4'd5, value: 32'h5555};
    tick();
    idle_inputs();
    chk("t5_count", 128'(count), 128'(2));
    chk("t5_shifted_op", 128'(issue_rs.op), 128'(8'h31));
    chk("t5_shifted_val", 128'(issue_rs.operand[0]), 128'(32'h5555));
    issue_ready = 1'b1;
    tick();
    chk("t5_new_op", 128'(issue_rs.op), 128'(8'h32));
    tick();
    issue_ready = 1'b0;
    chk("t5_drained", 128'(count), 128'(0));

    // Flush beats a concurrent dispatch.
    for (int k = 0; k < 3; k++) push(mk(2'b10, 4'd12, 32'd0, 32'd0, 8'(8'h40 + k)));
    flush          = 1'b1;
    dispatch_valid = 1'b1;
    dispatch_rs    = mk(2'b11, 4'd0, 32'd9, 32'd9, 8'h4F);
    tick();
    idle_inputs();
    chk("t6_flush_count", 128'(count), 128'(0));
    chk("t6_flush_issue_valid", 128'(issue_valid), 128'(0));
    tick();
    chk("t6_flush_not_stored", 128'(count), 128'(0));

    // Asynchronous reset mid-operation.
    for (int k = 0; k < 3; k++) push(mk(2'b11, 4'd0, 32'(k), 32'(k), 8'(8'h50 + k)));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_count", 128'(count), 128'(0));
    chk("t6_rst_issue_valid", 128'(issue_valid), 128'(0));
    chk("t6_rst_dispatch_ready", 128'(dispatch_ready), 128'(1));
    chk("t6_rst_issue_rs", 128'(issue_rs), 128'(0));
    mq.delete();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int t0;
      int t1;
      reserve_station_t e;
      dispatch_valid  = ($urandom_range(0, 2) != 0);
      e.op            = 8'($urandom);
      e.dest          = 4'($urandom_range(0, 15));
      e.operand_ready = 2'($urandom_range(0, 3));
      e.operand_addr[0] = 4'($urandom_range(0, 7));
      e.operand_addr[1] = 4'($urandom_range(0, 7));
      e.operand[0]    = $urandom;
      e.operand[1]    = $urandom;
      dispatch_rs     = e;
      issue_ready     = 1'($urandom_range(0, 1));
      flush           = ($urandom_range(0, 59) == 0);
      t0 = int'($urandom_range(0, 7));
      t1 = (t0 + int'($urandom_range(1, 7))) % 8;
      cdb_packet[0] = '{valid: 1'($urandom_range(0, 1)), reorder: 4'(t0), value: $urandom};
      cdb_packet[1] = '{valid: 1'($urandom_range(0, 1)), reorder: 4'(t1), value: $urandom};
      tick();
    end
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
